mod_exp_ctrl: RTL and testbench

Sequencer that computes y = base^exp mod m by scheduling a single external modular-multiplier instance through a right-to-left square-and-multiply loop. It sits between the coprocessor register file and one mod-mul datapath: it latches operands on a start pulse, issues multiply and square requests one at a time, captures results, and reports completion. It adds no arithmetic of its own beyond exponent shifting and operand checks.

---
 rtl/mod_exp_ctrl.sv | 148 ++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer that drives one external modular multiplier.
// Operands are latched on start_p; the result and error flag stay visible until the next start.
module mod_exp_ctrl #(
  parameter int unsigned NBITS = 256,
  parameter int unsigned EBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             done_p,
  output logic             err,
  output logic             busy,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  typedef enum logic [2:0] {
    StIdle,
    StEval,
    StWaitMul,
    StChkSqr,
    StWaitSqr,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] base_loc_q, base_loc_d;
  logic [NBITS-1:0] m_loc_q, m_loc_d;
  logic [NBITS-1:0] res_loc_q, res_loc_d;
  logic [EBITS-1:0] exp_loc_q, exp_loc_d;
  logic             err_loc_q, err_loc_d;
  logic [EBITS-1:0] exp_shr;

  assign exp_shr = exp_loc_q >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_loc_q <= '0;
      m_loc_q    <= '0;
      res_loc_q  <= '0;
      exp_loc_q  <= '0;
      err_loc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_loc_q <= base_loc_d;
      m_loc_q    <= m_loc_d;
      res_loc_q  <= res_loc_d;
      exp_loc_q  <= exp_loc_d;
      err_loc_q  <= err_loc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_loc_d   = base_loc_q;
    m_loc_d      = m_loc_q;
    res_loc_d    = res_loc_q;
    exp_loc_d    = exp_loc_q;
    err_loc_d    = err_loc_q;
    mul_enable_p = 1'b0;
    done_p       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_p) begin
          base_loc_d = base;
          exp_loc_d  = exp;
          m_loc_d    = m;
          res_loc_d  = NBITS'(1);
          err_loc_d  = (m < NBITS'(2)) | (base >= m);
          state_d    = StEval;
        end
      end
      StEval: begin
        if (err_loc_q) begin
          res_loc_d = '0;
          state_d   = StDone;
        end else if (exp_loc_q == '0) begin
          state_d = StDone;
        end else if (exp_loc_q[0]) begin
          mul_enable_p = 1'b1;
          state_d      = StWaitMul;
        end else begin
          state_d = StChkSqr;
        end
      end
      StWaitMul: begin
        if (mul_done_p) begin
          res_loc_d = mul_y;
          state_d   = StChkSqr;
        end
      end
      StChkSqr: begin
        exp_loc_d = exp_shr;
        // Skip the square that would only feed a bit that no longer exists.
        if (exp_shr == '0) begin
          state_d = StDone;
        end else begin
          mul_enable_p = 1'b1;
          state_d      = StWaitSqr;
        end
      end
      StWaitSqr: begin
        if (mul_done_p) begin
          base_loc_d = mul_y;
          state_d    = StEval;
        end
      end
      StDone: begin
        done_p  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operands come straight from registers that only change on capture, so they hold
  // from the request cycle through the completion cycle.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StEval, StWaitMul: begin
        mul_a = res_loc_q;
        mul_b = base_loc_q;
      end
      StChkSqr, StWaitSqr: begin
        mul_a = base_loc_q;
        mul_b = base_loc_q;
      end
      default: ;
    endcase
  end

  assign mul_m = m_loc_q;
  assign y     = res_loc_q;
  assign err   = err_loc_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural modular multiplier of adjustable latency.
module tb_mod_exp_ctrl;
  localparam int unsigned NB = 16;
  localparam int unsigned EB = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_p = 1'b0;
  logic [NB-1:0] base_i = '0;
  logic [EB-1:0] exp_i = '0;
  logic [NB-1:0] m_i = '0;
  logic [NB-1:0] y;
  logic          done_p, err, busy, mul_enable_p;
  logic [NB-1:0] mul_a, mul_b, mul_m;
  logic [NB-1:0] mul_y_dut;
  logic          mul_done_dut;

  logic          mul_done_m = 1'b0;
  logic [NB-1:0] mul_y_m = '0;
  logic          stray_done = 1'b0;
  logic [NB-1:0] stray_y = '0;

  assign mul_done_dut = mul_done_m | stray_done;
  assign mul_y_dut    = stray_done ? stray_y : mul_y_m;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_p     (start_p),
    .base        (base_i),
    .exp         (exp_i),
    .m           (m_i),
    .y           (y),
    .done_p      (done_p),
    .err         (err),
    .busy        (busy),
    .mul_enable_p(mul_enable_p),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_m       (mul_m),
    .mul_y       (mul_y_dut),
    .mul_done_p  (mul_done_dut)
  );

  // Multiplier model: answers lat cycles after a request, logs request kind (1 = square).
  int            lat = 1;
  bit            pend = 1'b0;
  int            cnt = 0;
  logic [NB-1:0] cap_a, cap_b, cap_m;
  int            nreq = 0;
  logic [31:0]   seq = '0;
  bit            stab_bad = 1'b0;

  always @(negedge clk) begin
    mul_done_m = 1'b0;
    if (pend) begin
      if (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cap_m) stab_bad = 1'b1;
      cnt--;
      if (cnt <= 0) begin
        mul_done_m = 1'b1;
        mul_y_m = (cap_m == '0) ? '0 :
                  NB'((longint'(cap_a) * longint'(cap_b)) % longint'(cap_m));
        pend = 1'b0;
      end
    end
    if (mul_enable_p === 1'b1) begin
      if (pend) stab_bad = 1'b1;
      pend  = 1'b1;
      cnt   = lat;
      cap_a = mul_a;
      cap_b = mul_b;
      cap_m = mul_m;
      nreq++;
      seq = {seq[30:0], (mul_a == mul_b)};
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic run_op(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] mm,
                        input int lt, input bit interfere, output logic [NB-1:0] ry,
                        output logic rerr, output int rcyc, output bit timed_out,
                        output bit pulse_bad);
    lat      = lt;
    nreq     = 0;
    seq      = '0;
    stab_bad = 1'b0;
    @(negedge clk); #1;
    start_p = 1'b1;
    base_i  = b;
    exp_i   = e;
    m_i     = mm;
    @(posedge clk); #1;
    start_p   = 1'b0;
    rcyc      = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      rcyc++;
      if (interfere && rcyc == 3) begin
        start_p = 1'b1;
        base_i  = 5;
        exp_i   = 0;
        m_i     = 7;
      end else begin
        start_p = 1'b0;
      end
      if (done_p === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    start_p = 1'b0;
    ry      = y;
    rerr    = err;
    @(negedge clk); #1;
    pulse_bad = (done_p !== 1'b0) || (busy !== 1'b0);
  endtask

  typedef struct {
    logic [NB-1:0] b;
    logic [EB-1:0] e;
    logic [NB-1:0] m;
    int            lt;
    logic [NB-1:0] y;
    logic          err;
    int            nreq;
    logic [31:0]   seq;
    int            cyc;  // 0: latency not checked
  } vec_t;

  vec_t vecs[13];

  task automatic check_run(input string tag, input logic [NB-1:0] ey, input logic eerr,
                           input int enreq, input logic [31:0] eseq, input int ecyc,
                           input logic [NB-1:0] ry, input logic rerr, input int rcyc,
                           input bit tmo, input bit pbad);
    chk({tag, " timeout"}, 64'(tmo), 0);
    chk({tag, " y"}, 64'(ry), 64'(ey));
    chk({tag, " err"}, 64'(rerr), 64'(eerr));
    chk({tag, " requests"}, 64'(nreq), 64'(enreq));
    chk({tag, " order"}, 64'(seq), 64'(eseq));
    chk({tag, " operand hold"}, 64'(stab_bad), 0);
    chk({tag, " idle after done"}, 64'(pbad), 0);
    if (ecyc != 0) chk({tag, " latency"}, 64'(rcyc), 64'(ecyc));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " y"}, 64'(y), 0);
    chk({tag, " done_p"}, 64'(done_p), 0);
    chk({tag, " err"}, 64'(err), 0);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " mul_enable_p"}, 64'(mul_enable_p), 0);
    chk({tag, " mul_a"}, 64'(mul_a), 0);
    chk({tag, " mul_b"}, 64'(mul_b), 0);
    chk({tag, " mul_m"}, 64'(mul_m), 0);
  endtask

  logic [NB-1:0] ry;
  logic          rerr;
  int            rcyc;
  bit            tmo, pbad, flag;

  initial begin
    vecs[0]  = '{16'd5,  16'd0,      16'd7,    2, 16'd1,   1'b0, 0,  32'h0,      2};
    vecs[1]  = '{16'd4,  16'd13,     16'd497,  3, 16'd445, 1'b0, 6,  32'b011010, 0};
    vecs[2]  = '{16'd2,  16'd10,     16'd1000, 1, 16'd24,  1'b0, 5,  32'b10110,  0};
    vecs[3]  = '{16'd0,  16'd0,      16'd1,    1, 16'd0,   1'b1, 0,  32'h0,      2};
    vecs[4]  = '{16'd3,  16'd1,      16'd7,    1, 16'd3,   1'b0, 1,  32'h0,      4};
    vecs[5]  = '{16'd9,  16'd5,      16'd7,    2, 16'd0,   1'b1, 0,  32'h0,      2};
    vecs[6]  = '{16'd3,  16'd5,      16'd7,    2, 16'd5,   1'b0, 4,  32'b0110,   0};
    vecs[7]  = '{16'd7,  16'd3,      16'd7,    1, 16'd0,   1'b1, 0,  32'h0,      2};
    vecs[8]  = '{16'd6,  16'd2,      16'd11,   4, 16'd3,   1'b0, 2,  32'b10,     0};
    vecs[9]  = '{16'd0,  16'd1,      16'd0,    1, 16'd0,   1'b1, 0,  32'h0,      2};
    vecs[10] = '{16'd0,  16'd2,      16'd5,    1, 16'd0,   1'b0, 2,  32'b10,     0};
    vecs[11] = '{16'd7,  16'h8000,   16'd13,   1, 16'd3,   1'b0, 16, 32'hFFFE,   0};
    vecs[12] = '{16'd12, 16'd3,      16'd13,   2, 16'd12,  1'b0, 3,  32'b010,    0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].lt, 1'b0, ry, rerr, rcyc, tmo, pbad);
      check_run($sformatf("v%0d", i), vecs[i].y, vecs[i].err, vecs[i].nreq, vecs[i].seq,
                vecs[i].cyc, ry, rerr, rcyc, tmo, pbad);
      if (tmo) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
      end
    end

    // Reset while a square is outstanding; its late completion must be ignored.
    lat = 6; nreq = 0; seq = '0;
    @(negedge clk); #1;
    start_p = 1'b1; base_i = 4; exp_i = 13; m_i = 497;
    @(negedge clk); #1;
    start_p = 1'b0;
    flag = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (nreq >= 2) begin
        flag = 1'b0;
        break;
      end
      @(negedge clk); #1;
    end
    chk("rst reached square", 64'(flag), 0);
    @(negedge clk); #1;
    chk("rst pre busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst mid-op");
    @(negedge clk); #1;
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (done_p !== 1'b0 || busy !== 1'b0 || mul_enable_p !== 1'b0) flag = 1'b1;
    end
    chk("rst late done ignored", 64'(flag), 0);
    chk("rst late y", 64'(y), 0);
    run_op(16'd3, 16'd5, 16'd7, 2, 1'b0, ry, rerr, rcyc, tmo, pbad);
    check_run("post-rst", 16'd5, 1'b0, 4, 32'b0110, 0, ry, rerr, rcyc, tmo, pbad);

    // Stray completion in idle, then a start pulse while busy.
    @(negedge clk); #1;
    stray_y = 16'd99; stray_done = 1'b1;
    @(negedge clk); #1;
    stray_done = 1'b0;
    @(negedge clk); #1;
    chk("stray busy", 64'(busy), 0);
    chk("stray y", 64'(y), 5);
    chk("stray done_p", 64'(done_p), 0);
    run_op(16'd2, 16'd10, 16'd1000, 2, 1'b1, ry, rerr, rcyc, tmo, pbad);
    check_run("restart", 16'd24, 1'b0, 5, 32'b10110, 0, ry, rerr, rcyc, tmo, pbad);
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (done_p !== 1'b0 || busy !== 1'b0) flag = 1'b1;
    end
    chk("restart no extra op", 64'(flag), 0);
    chk("restart y held", 64'(y), 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
